pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage core (IF, ID, EX, MEM, WB). It drives the enable and clear inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Hazard sources are memory stalls, multi-cycle EX ops, load-use hazards, EX branch redirects and I-fetch misses. It is the only block that drives those enable and clear nets; a clear dominates an enable at every register.

---
 rtl/pipe_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: drives PC and pipeline-register enables and clears.
// Optional perf counters are enabled with `define PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int LAT_W = 5,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mem_busy,
  input  logic             if_busy,
  input  logic             ex_mc_start,
  input  logic [LAT_W-1:0] ex_mc_lat,
  input  logic             ex_redirect,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             clr_ifid,
  output logic             clr_idex,
  output logic             clr_exmem,
  output logic             clr_memwb,
  output logic             pc_sel_redirect,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  output logic [31:0]      perf_stall_cyc,
  output logic [31:0]      perf_flush_cnt,
`endif
  output logic             stall_any
);

  typedef enum logic {RUN = 1'b0, MC_BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic             kill_q, kill_d;
  logic             lat_ge2, mc_stall, load_use, redirect_fire;

  // A latency of 0 behaves like 1, so only values above 1 start a stall.
  assign lat_ge2  = ex_mc_lat > LAT_W'(1);
  assign mc_stall = ((state_q == RUN) && ex_mc_start && lat_ge2) ||
                    ((state_q == MC_BUSY) && (cnt_q != LAT_W'(1)));
  assign load_use = ex_is_load && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (ex_mc_start && lat_ge2) begin
          state_d = MC_BUSY;
          cnt_d   = ex_mc_lat - LAT_W'(1);
        end
      end
      MC_BUSY: begin
        // The last EX cycle waits for MEM to drain before the op can retire.
        if (cnt_q > LAT_W'(1)) begin
          cnt_d = cnt_q - LAT_W'(1);
        end else if (!mem_busy) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    en_pc           = 1'b1;
    en_ifid         = 1'b1;
    en_idex         = 1'b1;
    en_exmem        = 1'b1;
    en_memwb        = 1'b1;
    clr_ifid        = 1'b0;
    clr_idex        = 1'b0;
    clr_exmem       = 1'b0;
    clr_memwb       = 1'b0;
    pc_sel_redirect = 1'b0;
    redirect_fire   = 1'b0;
    kill_d          = kill_q;
    if (!rstn) begin
      en_pc     = 1'b0;
      en_ifid   = 1'b0;
      en_idex   = 1'b0;
      en_exmem  = 1'b0;
      en_memwb  = 1'b0;
      clr_ifid  = 1'b1;
      clr_idex  = 1'b1;
      clr_exmem = 1'b1;
      clr_memwb = 1'b1;
    end else if (mem_busy) begin
      en_pc     = 1'b0;
      en_ifid   = 1'b0;
      en_idex   = 1'b0;
      en_exmem  = 1'b0;
      clr_memwb = 1'b1;
    end else if (mc_stall) begin
      en_pc     = 1'b0;
      en_ifid   = 1'b0;
      en_idex   = 1'b0;
      clr_exmem = 1'b1;
    end else if (ex_redirect) begin
      pc_sel_redirect = 1'b1;
      clr_ifid        = 1'b1;
      clr_idex        = 1'b1;
      redirect_fire   = 1'b1;
      // An outstanding fetch belongs to the wrong path and must be dropped on return.
      kill_d          = if_busy;
    end else if (load_use) begin
      en_pc    = 1'b0;
      en_ifid  = 1'b0;
      clr_idex = 1'b1;
    end else if (kill_q && !if_busy) begin
      en_pc    = 1'b0;
      clr_ifid = 1'b1;
      kill_d   = 1'b0;
    end else if (if_busy) begin
      en_pc    = 1'b0;
      clr_ifid = 1'b1;
    end
  end

  assign stall_any = !en_pc || !en_ifid || !en_idex || !en_exmem;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= RUN;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cyc_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_any)     stall_cyc_q <= stall_cyc_q + 32'd1;
      if (redirect_fire) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cyc = stall_cyc_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected output vectors are queued as stimulus is
// driven and compared at the following negedge.
module tb_pipe_hazard_ctrl;
  localparam int LAT_W = 5;
  localparam int REG_W = 5;

  // {en_pc,en_ifid,en_idex,en_exmem,en_memwb,clr_ifid,clr_idex,clr_exmem,clr_memwb,pc_sel,stall_any}
  localparam logic [10:0] V_RST = 11'b00000_1111_0_1;
  localparam logic [10:0] V_RUN = 11'b11111_0000_0_0;
  localparam logic [10:0] V_MEM = 11'b00001_0001_0_1;
  localparam logic [10:0] V_MC  = 11'b00011_0010_0_1;
  localparam logic [10:0] V_RED = 11'b11111_1100_1_0;
  localparam logic [10:0] V_LU  = 11'b00111_0100_0_1;
  localparam logic [10:0] V_IFK = 11'b01111_1000_0_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstn, mem_busy, if_busy, ex_mc_start, ex_redirect, ex_is_load;
  logic [LAT_W-1:0] ex_mc_lat;
  logic [REG_W-1:0] ex_rd, id_rs1, id_rs2;
  logic             id_use_rs1, id_use_rs2;
  logic en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic clr_ifid, clr_idex, clr_exmem, clr_memwb, pc_sel_redirect, stall_any;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

  pipe_hazard_ctrl #(.LAT_W(LAT_W), .REG_W(REG_W)) dut (
    .clk(clk), .rstn(rstn), .mem_busy(mem_busy), .if_busy(if_busy),
    .ex_mc_start(ex_mc_start), .ex_mc_lat(ex_mc_lat), .ex_redirect(ex_redirect),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem),
    .en_memwb(en_memwb), .clr_ifid(clr_ifid), .clr_idex(clr_idex),
    .clr_exmem(clr_exmem), .clr_memwb(clr_memwb), .pc_sel_redirect(pc_sel_redirect),
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt),
`endif
    .stall_any(stall_any)
  );

  typedef struct {
    logic [10:0] vec;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  function automatic logic [10:0] obs_vec();
    return {en_pc, en_ifid, en_idex, en_exmem, en_memwb,
            clr_ifid, clr_idex, clr_exmem, clr_memwb, pc_sel_redirect, stall_any};
  endfunction

  task automatic idle_inputs();
    mem_busy = 0; if_busy = 0; ex_mc_start = 0; ex_mc_lat = '0; ex_redirect = 0;
    ex_is_load = 0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
  endtask

  // One cycle: queue the expectation, sample at negedge, advance to just past the next posedge.
  task automatic step(input logic [10:0] e, input string nm);
    exp_t        t;
    exp_t        got;
    logic [10:0] o;
    t.vec  = e;
    t.name = nm;
    exp_q.push_back(t);
    @(negedge clk);
    o   = obs_vec();
    got = exp_q.pop_front();
    checks++;
    if (o !== got.vec) begin
      errors++;
      $display("FAIL %s: outputs=%b expected=%b", got.name, o, got.vec);
    end else begin
      $display("txn %-18s outputs=%b", got.name, o);
    end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    checks++;
    if (perf_stall_cyc !== m_stall) begin
      errors++;
      $display("FAIL %s_perf_stall: got=%0d expected=%0d", got.name, perf_stall_cyc, m_stall);
    end
    checks++;
    if (perf_flush_cnt !== m_flush) begin
      errors++;
      $display("FAIL %s_perf_flush: got=%0d expected=%0d", got.name, perf_flush_cnt, m_flush);
    end
    if (!rstn) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (got.vec[0]) m_stall++;
      if (got.vec[1]) m_flush++;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 0;
    idle_inputs();
    step(V_RST, "reset_0");
    step(V_RST, "reset_1");
    rstn = 1;
    step(V_RUN, "post_reset_idle");
  endtask

  task automatic test_load_use();
    ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    step(V_LU, "lu_rs1");
    idle_inputs();
    step(V_RUN, "lu_rs1_release");
    ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    step(V_RUN, "lu_rd_zero");
    idle_inputs();
    ex_is_load = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
    step(V_LU, "lu_rs2");
    idle_inputs();
    ex_is_load = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 0;
    step(V_RUN, "lu_rs1_unused");
    idle_inputs();
    ex_is_load = 0; ex_rd = 9; id_rs1 = 9; id_use_rs1 = 1;
    step(V_RUN, "lu_not_load");
    idle_inputs();
  endtask

  task automatic test_multicycle();
    ex_mc_start = 1; ex_mc_lat = 4;
    step(V_MC, "mc4_c0");
    idle_inputs();
    step(V_MC, "mc4_c1");
    step(V_MC, "mc4_c2");
    step(V_RUN, "mc4_c3_advance");
    step(V_RUN, "mc4_after");
    for (int l = 0; l < 2; l++) begin
      ex_mc_start = 1; ex_mc_lat = LAT_W'(l);
      step(V_RUN, $sformatf("mc_lat%0d", l));
      idle_inputs();
      step(V_RUN, $sformatf("mc_lat%0d_after", l));
    end
    ex_mc_start = 1; ex_mc_lat = 2;
    step(V_MC, "mc2_c0");
    idle_inputs();
    step(V_RUN, "mc2_c1");
  endtask

  task automatic test_overlap();
    ex_mc_start = 1; ex_mc_lat = 3; mem_busy = 1;
    step(V_MEM, "ovl_c0");
    ex_mc_start = 0; ex_mc_lat = 0;
    for (int i = 1; i < 5; i++) step(V_MEM, $sformatf("ovl_c%0d", i));
    mem_busy = 0;
    step(V_RUN, "ovl_advance");
    step(V_RUN, "ovl_after");
  endtask

  task automatic test_redirect_imiss();
    ex_redirect = 1; if_busy = 1;
    step(V_RED, "rdi_redirect");
    ex_redirect = 0;
    step(V_IFK, "rdi_miss_1");
    step(V_IFK, "rdi_miss_2");
    if_busy = 0;
    step(V_IFK, "rdi_kill_drop");
    step(V_RUN, "rdi_after");
    ex_redirect = 1; if_busy = 0;
    step(V_RED, "rd_no_miss");
    ex_redirect = 0;
    step(V_RUN, "rd_no_miss_after");
  endtask

  task automatic test_priority();
    mem_busy = 1; ex_redirect = 1;
    ex_is_load = 1; ex_rd = 4; id_rs1 = 4; id_use_rs1 = 1;
    step(V_MEM, "pri_mem_wins");
    mem_busy = 0;
    step(V_RED, "pri_redirect");
    idle_inputs();
    step(V_RUN, "pri_after");
    ex_mc_start = 1; ex_mc_lat = 3; ex_redirect = 1;
    step(V_MC, "pri_mc_c0");
    ex_mc_start = 0; ex_mc_lat = 0;
    step(V_MC, "pri_mc_c1");
    step(V_RED, "pri_mc_redirect");
    idle_inputs();
    step(V_RUN, "pri_mc_after");
  endtask

  task automatic test_reset_mid_op();
    ex_mc_start = 1; ex_mc_lat = 5;
    step(V_MC, "rmo_c0");
    idle_inputs();
    step(V_MC, "rmo_c1");
    rstn = 0;
    step(V_RST, "rmo_reset");
    rstn = 1;
    step(V_RUN, "rmo_released");
    step(V_RUN, "rmo_idle");
  endtask

  task automatic test_back_to_back();
    ex_is_load = 1; ex_rd = 6; id_rs1 = 6; id_use_rs1 = 1;
    step(V_LU, "b2b_lu_0");
    ex_rd = 8; id_rs2 = 8; id_use_rs2 = 1; id_use_rs1 = 0;
    step(V_LU, "b2b_lu_1");
    idle_inputs();
    ex_redirect = 1; if_busy = 1;
    step(V_RED, "b2b_red_0");
    step(V_RED, "b2b_red_1");
    ex_redirect = 0;
    step(V_IFK, "b2b_miss");
    if_busy = 0;
    step(V_IFK, "b2b_kill_drop");
    step(V_RUN, "b2b_after");
  endtask

  initial begin
    rstn = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_multicycle();
    test_overlap();
    test_redirect_imiss();
    test_priority();
    test_reset_mid_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
